// File: rtl/rv_pkg.sv
// Shared RV32M definitions: funct3 opcodes, datapath widths and the muldiv FSM state encoding.
package rv_pkg;
  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/muldiv_unit_if.sv
// Request/write-back bundle between the execute stage and the iterative mul/div unit.
interface muldiv_unit_if;
  import rv_pkg::*;

  logic            start;
  logic            kill;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [4:0]      rd;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      wr;
  logic            we;

  modport master (output start, kill, op, rs1, rs2, rd,
                  input  busy, done, result, wr, we);
  modport slave  (input  start, kill, op, rs1, rs2, rd,
                  output busy, done, result, wr, we);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: shift-add multiply / restoring divide on magnitudes, one bit per cycle.
// Fixed 33-edge accept-to-done latency, single outstanding op; start only taken in IDLE.
module muldiv_unit
  import rv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     opb_q;
  logic [2:0]          op_q;
  logic [4:0]          rd_q;
  logic                neg_q;
  logic                negr_q;
  logic                dz_q;
  logic [XLEN-1:0]     result_q;
  logic [4:0]          wr_q;

  logic                accept;
  logic                a_sgn, b_sgn;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       mul_sum, div_diff;
  logic [2*XLEN-1:0]   mul_next, div_next, prod;
  logic [XLEN-1:0]     quo, rem, fix_res;

  assign accept = (state_q == IDLE) && bus.start && !bus.kill;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (cnt_q == CNT_W'(XLEN-1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.kill) state_d = IDLE;
  end

  // FSM: outputs
  always_comb begin
    bus.busy = (state_q == CALC) || (state_q == FIX);
    bus.done = (state_q == DONE);
    bus.we   = (state_q == DONE) && (rd_q != 5'd0);
  end

  assign bus.result = result_q;
  assign bus.wr     = wr_q;

  // MULHU/DIVU/REMU and MUL (low word is sign-agnostic) run fully unsigned.
  always_comb begin
    a_sgn = bus.rs1[XLEN-1] && (bus.op == OP_MULH || bus.op == OP_MULHSU ||
                                bus.op == OP_DIV  || bus.op == OP_REM);
    b_sgn = bus.rs2[XLEN-1] && (bus.op == OP_MULH || bus.op == OP_DIV ||
                                bus.op == OP_REM);
    a_mag = a_sgn ? -bus.rs1 : bus.rs1;
    b_mag = b_sgn ? -bus.rs2 : bus.rs2;
  end

  // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
  end

  // Divide: high half is the partial remainder, quotient bits enter at the bottom.
  always_comb begin
    div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
    div_next = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = acc_q[XLEN-1:0];
    rem  = acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                         fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:                fix_res = dz_q ? '1 : (neg_q ? -quo : quo);
      default:                        fix_res = negr_q ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
      wr_q     <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      acc_q  <= {{XLEN{1'b0}}, a_mag};
      opb_q  <= b_mag;
      op_q   <= bus.op;
      rd_q   <= bus.rd;
      neg_q  <= a_sgn ^ b_sgn;
      negr_q <= a_sgn;
      dz_q   <= bus.op[2] && (bus.rs2 == '0);
    end else if (state_q == CALC) begin
      acc_q <= op_q[2] ? div_next : mul_next;
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (state_q == FIX && !bus.kill) begin
      result_q <= fix_res;
      wr_q     <= rd_q;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, 33-edge latency, handshake, kill and async reset.
module tb_muldiv_unit;
  import rv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;

  muldiv_unit_if bus ();
  muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // poke=1 changes rs1 after E1 and re-asserts start mid-operation.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input bit poke);
    int lat = 0;
    int busy_low = 0;
    int extra = 0;
    bus.op = op; bus.rs1 = a; bus.rs2 = b; bus.rd = rd; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int e = 1; e <= 40 && lat == 0; e++) begin
      @(posedge clk); #1;
      if (bus.done) lat = e;
      else if (!bus.busy) busy_low++;
      if (poke && e == 1) bus.rs1 = 32'h1234_5678;
      if (poke && e == 5) begin
        bus.start = 1'b1; bus.op = OP_MUL; bus.rs2 = 32'd9; bus.rd = 5'd1;
      end
      if (poke && e == 6) bus.start = 1'b0;
    end
    check({tag, "/latency"}, lat, 33);
    check({tag, "/busy_low"}, busy_low, 0);
    check({tag, "/result"}, bus.result, exp);
    check({tag, "/wr"}, {27'd0, bus.wr}, {27'd0, rd});
    check({tag, "/we"}, {31'd0, bus.we}, {31'd0, rd != 5'd0});
    check({tag, "/busy_done"}, {31'd0, bus.busy}, 0);
    @(posedge clk); #1;
    check({tag, "/done_pulse"}, {31'd0, bus.done}, 0);
    check({tag, "/we_pulse"}, {31'd0, bus.we}, 0);
    if (poke) begin
      for (int e = 0; e < 40; e++) begin
        @(posedge clk); #1;
        if (bus.done) extra++;
      end
      check({tag, "/extra_done"}, extra, 0);
      check({tag, "/hold"}, bus.result, exp);
    end
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    bus.start = 1'b0; bus.kill = 1'b0; bus.op = '0;
    bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/busy", {31'd0, bus.busy}, 0);
    check("rst/done", {31'd0, bus.done}, 0);
    check("rst/we", {31'd0, bus.we}, 0);
    check("rst/result", bus.result, 0);
    check("rst/wr", {27'd0, bus.wr}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("mul",      OP_MUL,    32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0);
    run_op("mulh",     OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 1'b0);
    run_op("mulhu",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 1'b0);
    run_op("mulhsu",   OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 1'b0);
    run_op("div",      OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 1'b0);
    run_op("rem",      OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 1'b0);
    run_op("divu",     OP_DIVU,   32'd100,       32'd7,         5'd11, 32'd14,        1'b0);
    run_op("remu",     OP_REMU,   32'd100,       32'd7,         5'd12, 32'd2,         1'b0);
    run_op("div0",     OP_DIV,    32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1'b0);
    run_op("rem0",     OP_REM,    32'd5,         32'd0,         5'd14, 32'd5,         1'b0);
    run_op("divu0",    OP_DIVU,   32'hFFFF_FFF9, 32'd0,         5'd15, 32'hFFFF_FFFF, 1'b0);
    run_op("divovf",   OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1'b0);
    run_op("removf",   OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         1'b0);
    run_op("rd0",      OP_MUL,    32'd3,         32'd4,         5'd0,  32'd12,        1'b0);
    run_op("poke",     OP_DIVU,   32'd100,       32'd7,         5'd18, 32'd14,        1'b1);

    // kill sampled at E10
    bus.op = OP_MUL; bus.rs1 = 32'd6; bus.rs2 = 32'd7; bus.rd = 5'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    check("kill/busy", {31'd0, bus.busy}, 0);
    seen = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (bus.done || bus.we || bus.busy) seen++;
    end
    check("kill/no_done", seen, 0);
    check("kill/result", bus.result, 32'd14);

    // start and kill together in IDLE
    bus.start = 1'b1; bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.kill = 1'b0;
    check("startkill/busy", {31'd0, bus.busy}, 0);
    @(posedge clk); #1;
    check("startkill/busy2", {31'd0, bus.busy}, 0);

    // async reset between E14 and E15
    bus.op = OP_MUL; bus.rs1 = 32'd6; bus.rs2 = 32'd7; bus.rd = 5'd4; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("arst/busy", {31'd0, bus.busy}, 0);
    check("arst/done", {31'd0, bus.done}, 0);
    check("arst/we", {31'd0, bus.we}, 0);
    check("arst/result", bus.result, 0);
    check("arst/wr", {27'd0, bus.wr}, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run_op("post_rst", OP_MUL, 32'd6, 32'd7, 5'd4, 32'd42, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
